// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
// master drives operations and accepts results; slave is the adder core.
interface pipelined_adder_if #(
  parameter int WIDTH = 9
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;
  logic             ovf;

  modport master (
    output in_valid,
    output in0,
    output in1,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  in0,
    input  in1,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output ovf
  );

endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-segmented pipelined adder/subtractor
// One register stage per SEG-bit carry segment; all stages advance together under a global enable.
module pipelined_adder #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 3
) (
  input logic               clk,
  input logic               resetn,
  pipelined_adder_if.slave  bus
);

  localparam int SEG = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  logic adv;

  // Per-stage registers: index k holds the result of segment k.
  logic             v_r [STAGES];
  logic             c_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];

  logic             n_v [STAGES];
  logic             n_c [STAGES];
  logic [WIDTH-1:0] n_s [STAGES];
  logic [WIDTH-1:0] n_a [STAGES];
  logic [WIDTH-1:0] n_b [STAGES];
  logic             ovf_n;

  logic [WIDTH:0]   out_r;
  logic             ovf_r;

  always_comb begin
    logic             cur_v;
    logic             cur_c;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] cur_s;
    logic [SEG:0]     seg_sum;
    cur_v   = 1'b0;
    cur_c   = 1'b0;
    cur_a   = '0;
    cur_b   = '0;
    cur_s   = '0;
    seg_sum = '0;
    ovf_n   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        cur_v = bus.in_valid;
        cur_a = bus.in0;
        cur_b = bus.sub ? ~bus.in1 : bus.in1;
        cur_s = '0;
        cur_c = bus.sub;
      end else begin
        cur_v = v_r[k-1];
        cur_a = a_r[k-1];
        cur_b = b_r[k-1];
        cur_s = s_r[k-1];
        cur_c = c_r[k-1];
      end
      seg_sum = {1'b0, SEG'(cur_a >> (k * SEG))}
              + {1'b0, SEG'(cur_b >> (k * SEG))}
              + (SEG + 1)'(cur_c);
      // Finished lower bits ride along; this stage fills in its own segment.
      n_s[k] = cur_s | (WIDTH'(seg_sum[SEG-1:0]) << (k * SEG));
      n_c[k] = seg_sum[SEG];
      n_a[k] = cur_a;
      n_b[k] = cur_b;
      n_v[k] = cur_v;
      if (k == STAGES - 1) begin
        ovf_n = (cur_a[WIDTH-1] == cur_b[WIDTH-1]) && (n_s[k][WIDTH-1] != cur_a[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        c_r[k] <= 1'b0;
        s_r[k] <= '0;
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
      out_r <= '0;
      ovf_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= n_v[k];
        c_r[k] <= n_c[k];
        s_r[k] <= n_s[k];
        a_r[k] <= n_a[k];
        b_r[k] <= n_b[k];
      end
      // Result registers only load real operations so out holds across bubbles.
      if (n_v[STAGES-1]) begin
        out_r <= {n_c[STAGES-1], n_s[STAGES-1]};
        ovf_r <= ovf_n;
      end
    end
  end

  assign adv           = ~v_r[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_r[STAGES-1];
  assign bus.out       = out_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder
// Main DUT is 9-bit/3-stage; a 16-bit sweep over STAGES runs alongside.
module tb_pipelined_adder;

  localparam int W = 9;
  localparam int S = 3;

  typedef struct packed {
    logic [W:0] out;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic resetn;
  logic sweep_rstn;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   sweep_done = 0;
  res_t exp_q[$];
  int   retire_cyc[$];

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed readings of the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t m;
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    if (!s) begin
      m.out = (W + 1)'(ua + ub);
      r = sa + sb;
    end else begin
      m.out[W]     = (ua >= ub);
      m.out[W-1:0] = W'((ua - ub) & ((1 << W) - 1));
      r = sa - sb;
    end
    m.ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    return m;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output logic fired);
    bus.in_valid = v;
    bus.in0      = a;
    bus.in1      = b;
    bus.sub      = s;
    #1;
    fired = v && bus.in_ready;
    if (fired) exp_q.push_back(model(a, b, s));
  endtask

  logic       prev_stall = 1'b0;
  logic [W:0] prev_out   = '0;
  logic       prev_ovf   = 1'b0;

  always @(negedge clk) begin
    #2;
    if (resetn !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_eq", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_out", bus.out, prev_out);
        check("hold_ovf", bus.ovf, prev_ovf);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", bus.out);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("result_out", bus.out, e.out);
          check("result_ovf", bus.ovf, e.ovf);
          retire_cyc.push_back(cycle);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = bus.out;
      prev_ovf   = bus.ovf;
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W:0] exp_out, input logic exp_ovf, input string name);
    logic f;
    int   lat;
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, s, f);
    check({name, "_accept"}, f, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.in_valid = 1'b0;
      #1;
    end while (!bus.out_valid && lat < 20);
    check({name, "_latency"}, lat, S);
    check({name, "_out"}, bus.out, exp_out);
    check({name, "_ovf"}, bus.ovf, exp_ovf);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int   n;
    logic f;
    drive(1'b0, '0, '0, 1'b0, f);
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  generate
    for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int SS = 1 << g;
      pipelined_adder_if #(.WIDTH(16)) sif ();
      pipelined_adder #(.WIDTH(16), .STAGES(SS)) sdut (
        .clk    (clk),
        .resetn (sweep_rstn),
        .bus    (sif)
      );
      initial begin
        int lat;
        sif.in_valid  = 1'b0;
        sif.in0       = '0;
        sif.in1       = '0;
        sif.sub       = 1'b0;
        sif.out_ready = 1'b1;
        wait (sweep_rstn === 1'b1);
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in0      = 16'hFFFF;
        sif.in1      = 16'h0001;
        #1;
        check($sformatf("sweep%0d_accept", SS), sif.in_ready, 1);
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
          sif.in_valid = 1'b0;
          #1;
        end while (!sif.out_valid && lat < 40);
        check($sformatf("sweep%0d_latency", SS), lat, SS);
        check($sformatf("sweep%0d_out", SS), sif.out, 17'h10000);
        check($sformatf("sweep%0d_ovf", SS), sif.ovf, 0);
        sweep_done++;
      end
    end
  endgenerate

  initial begin
    logic f;
    logic pending;
    logic [W-1:0] pa, pb;
    logic ps;
    int accepted, n;

    resetn        = 1'b0;
    sweep_rstn    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in0       = '0;
    bus.in1       = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out", bus.out, 0);
    check("reset_ovf", bus.ovf, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    resetn     = 1'b1;
    sweep_rstn = 1'b1;
    @(negedge clk);

    do_op(9'd511, 9'd511, 1'b0, 10'h3FE, 1'b0, "add_max");
    do_op(9'd5,   9'd7,   1'b1, 10'h1FE, 1'b0, "sub_borrow");
    do_op(9'd7,   9'd5,   1'b1, 10'h202, 1'b0, "sub_noborrow");
    do_op(9'd255, 9'd1,   1'b0, 10'h100, 1'b1, "add_ovf");
    do_op(9'd256, 9'd1,   1'b1, 10'h2FF, 1'b1, "sub_ovf");

    // Back-to-back stream with the sink always ready.
    retire_cyc.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), f);
      check("stream_accept", f, 1);
      @(negedge clk);
    end
    drain("stream_drain");
    check("stream_count", retire_cyc.size(), 20);
    if (retire_cyc.size() >= 20)
      check("stream_consecutive", retire_cyc[19] - retire_cyc[0], 19);

    // Random backpressure; each op is held until it transfers.
    accepted = 0;
    pending  = 1'b0;
    pa = '0; pb = '0; ps = 1'b0;
    n = 0;
    while (accepted < 40 && n < 2000) begin
      bus.out_ready = 1'($urandom);
      if (!pending) begin
        pa = W'($urandom);
        pb = W'($urandom);
        ps = 1'($urandom);
        pending = 1'b1;
      end
      drive(1'b1, pa, pb, ps, f);
      if (f) begin
        accepted++;
        pending = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("stall_accepted", accepted, 40);
    drain("stall_drain");

    // Reset with three operations in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), f);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    check("preflight_valid", bus.out_valid, 1);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    do_op(9'd100, 9'd27, 1'b0, 10'd127, 1'b0, "post_reset");

    n = 0;
    while (sweep_done < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sweep_done", sweep_done, 4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
